udp_reg_ring_master: RTL
========================

Name: udp_reg_ring_master

Overview:
Initiator at the head of the UDP register ring. It accepts one register access at a time from a host/CPCI-side core port and launches it onto the daisy-chained reg_req/ack/rd_wr_L/addr/data/src ring. It then collects the transaction when it returns from the ring tail and reports the data and status back to the core. It supplies the counterpart to every per-block register responder on the ring, and adds a timeout and no-responder detection.

Parameters:
UDP_REG_SRC_WIDTH, 2, width of reg_src tag
SRC_ID, 0, source tag this master stamps on its requests; only returns carrying this tag are accepted
TIMEOUT, 255, cycles to wait for the return before aborting (1..2^16-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
core_req  in  1  one-cycle pulse; core_rd_wr_L/addr/wr_data valid this cycle
core_rd_wr_L  in  1  1=read, 0=write
core_addr  in  `UDP_REG_ADDR_WIDTH  register address
core_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data
core_busy  out  1  high from accept until core_ack inclusive
core_ack  out  1  one-cycle completion pulse
core_rd_data  out  `CPCI_NF2_DATA_WIDTH  returned data; held until next ack
core_err  out  2  status with core_ack: 00 ok, 01 no responder, 10 timeout
reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring head
reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring head
reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring head
reg_src_out  out  UDP_REG_SRC_WIDTH  ring head
reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring tail
reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring tail
reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring tail
reg_src_in  in  UDP_REG_SRC_WIDTH  ring tail
stale_cnt  out  8  count of discarded returns, saturating

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0, including core_rd_data, core_err and stale_cnt. Timeout counter is 0.
- FSM: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
- IDLE: core_req=1 captures rd_wr_L, addr and wr_data, then goes to LAUNCH. core_req in any other state is ignored; no queueing.
- LAUNCH (1 cycle, registered outputs): drives reg_req_out=1, reg_ack_out=0, reg_rd_wr_L_out=captured, reg_addr_out=captured, reg_src_out=SRC_ID.
  - reg_data_out = wr_data for writes, 0 for reads.
  - Net latency: core_req at cycle T gives reg_req_out high at T+1, for exactly one cycle.
- All other cycles: reg_req_out=0 and reg_ack_out=0. The other ring outputs hold their last values.
- WAIT: counter increments each cycle.
  - Match = reg_req_in=1 and reg_src_in==SRC_ID.
  - On match with reg_ack_in=1: core_rd_data<=reg_data_in (reads); for writes core_rd_data is unchanged. core_err=00.
  - On match with reg_ack_in=0: core_rd_data<=32'hdead_beef, core_err=01.
  - When counter==TIMEOUT with no match: core_rd_data<=32'hdead_beef, core_err=10.
  - A match and the timeout in the same cycle: the match wins.
  - All three cases go to DONE.
- DONE: core_ack=1 for exactly one cycle, core_err valid, then IDLE. Minimum round trip with a 0-stage ring: ack at T+3.
- Discard: reg_req_in=1 with src!=SRC_ID in any state, or any return seen while not in WAIT (e.g. a late return after timeout), increments stale_cnt (saturates at 255) and is otherwise ignored.
- Returning address/rd_wr_L are not checked against the request.
- core_busy = state!=IDLE.
- Reset mid-transaction aborts immediately with no core_ack. A later stale return is counted.

Decomposition:
- Shared package: FSM state encoding, core_err code constants, DEADBEEF constant. Widths come from the existing global defines.
- One natural sub-module: udp_reg_timeout_ctr (loadable saturating counter with clear/enable, terminal-count output).

Test Plan:
- Read, ring with 2 register stages that loop back ack=1, data=32'h1234_5678 -> reg_req_out pulse at T+1; core_ack at T+5; core_rd_data=32'h1234_5678; core_err=00.
- Write addr 23'h40_0004, data 32'hcafe_f00d, responder acks -> reg_data_out=32'hcafe_f00d during the launch cycle; core_ack with err 00; core_rd_data unchanged.
- Return with ack=0 -> core_rd_data=32'hdead_beef, core_err=01.
- No return, TIMEOUT=16 -> core_ack 16 cycles into WAIT with err=10; a return injected 5 cycles later -> stale_cnt=1, no extra core_ack.
- Return with src=SRC_ID+1 during WAIT -> ignored, stale_cnt+1; a later matching return completes normally. core_req pulsed while busy -> no second launch.
- Assert reset in WAIT -> all outputs 0 asynchronously, state IDLE; a new request after release completes.

Source files
------------

// File: rtl/udp_reg_ring_master_pkg.sv
// Shared types and constants for the UDP register ring master.
// Provides fallback widths when the global defines are not already set.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package udp_reg_ring_master_pkg;

    localparam int ADDR_W = `UDP_REG_ADDR_WIDTH;
    localparam int DATA_W = `CPCI_NF2_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NO_RESP = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [DATA_W-1:0] DEADBEEF = DATA_W'(32'hdead_beef);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/udp_reg_ring_master_if.sv
// Core-side access port of the ring master: one request in, one completion out.
// The master modport is the host side, the slave modport is the ring master.
interface udp_reg_ring_master_if;

    logic                                        core_req;
    logic                                        core_rd_wr_L;
    logic [udp_reg_ring_master_pkg::ADDR_W-1:0]  core_addr;
    logic [udp_reg_ring_master_pkg::DATA_W-1:0]  core_wr_data;
    logic                                        core_busy;
    logic                                        core_ack;
    logic [udp_reg_ring_master_pkg::DATA_W-1:0]  core_rd_data;
    logic [1:0]                                  core_err;

    modport master (
        output core_req, core_rd_wr_L, core_addr, core_wr_data,
        input  core_busy, core_ack, core_rd_data, core_err
    );

    modport slave (
        input  core_req, core_rd_wr_L, core_addr, core_wr_data,
        output core_busy, core_ack, core_rd_data, core_err
    );

endinterface

// File: rtl/udp_reg_timeout_ctr.sv
// Loadable up-counter with clear/enable that sticks at all-ones,
// flagging when it equals the terminal value.
module udp_reg_timeout_ctr #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/udp_reg_ring_master.sv
// Head-of-ring initiator: launches one core register access onto the UDP
// register ring and reports the returning data/status, with timeout.
module udp_reg_ring_master
    import udp_reg_ring_master_pkg::*;
#(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int SRC_ID            = 0,
    parameter int TIMEOUT           = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    udp_reg_ring_master_if.slave         core,

    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [ADDR_W-1:0]            reg_addr_out,
    output logic [DATA_W-1:0]            reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [ADDR_W-1:0]            reg_addr_in,
    input  logic [DATA_W-1:0]            reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

    output logic [7:0]                   stale_cnt
);

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC = UDP_REG_SRC_WIDTH'(SRC_ID);

    state_t                       state, state_nxt;
    logic                         req_p1, ack_p1;
    logic [DATA_W-1:0]            data_p1;
    logic [UDP_REG_SRC_WIDTH-1:0] src_p1;
    logic                         match, stale_evt, tc;
    logic [DATA_W-1:0]            rd_data_q;
    logic [1:0]                   err_q;
    logic                         unused_ring_fields;

    // The returning address and direction are deliberately not compared.
    assign unused_ring_fields = ^{reg_addr_in, reg_rd_wr_L_in};

    // Tail stage: register the ring return before acting on it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_p1  <= 1'b0;
            ack_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else begin
            req_p1  <= reg_req_in;
            ack_p1  <= reg_ack_in;
            data_p1 <= reg_data_in;
            src_p1  <= reg_src_in;
        end
    end

    assign match     = req_p1 && (src_p1 == SRC);
    assign stale_evt = req_p1 && (!match || (state != ST_WAIT));

    udp_reg_timeout_ctr #(
        .WIDTH    (16),
        .TERMINAL (16'(TIMEOUT))
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == ST_LAUNCH),
        .load     (1'b0),
        .load_val (16'd0),
        .en       (state == ST_WAIT),
        .tc       (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (core.core_req) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (match || tc) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Launch stage: ring head is registered as the request is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out <= 1'b0;
            if ((state == ST_IDLE) && core.core_req) begin
                reg_req_out     <= 1'b1;
                reg_rd_wr_L_out <= core.core_rd_wr_L;
                reg_addr_out    <= core.core_addr;
                reg_data_out    <= core.core_rd_wr_L ? '0 : core.core_wr_data;
                reg_src_out     <= SRC;
            end
        end
    end

    // Completion stage: a match takes priority over a coincident timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            err_q     <= ERR_OK;
            stale_cnt <= 8'd0;
        end else begin
            if (state == ST_WAIT) begin
                if (match) begin
                    if (ack_p1) begin
                        if (reg_rd_wr_L_out) rd_data_q <= data_p1;
                        err_q <= ERR_OK;
                    end else begin
                        rd_data_q <= DEADBEEF;
                        err_q     <= ERR_NO_RESP;
                    end
                end else if (tc) begin
                    rd_data_q <= DEADBEEF;
                    err_q     <= ERR_TIMEOUT;
                end
            end
            if (stale_evt) stale_cnt <= sat_inc8(stale_cnt);
        end
    end

    assign reg_ack_out       = 1'b0;
    assign core.core_busy    = (state != ST_IDLE);
    assign core.core_ack     = (state == ST_DONE);
    assign core.core_rd_data = rd_data_q;
    assign core.core_err     = err_q;

endmodule
